// File: rtl/wr_fifo_burst_pkg.sv
// Shared types and constants for the FIFO-to-AXI burst writer.
package wr_fifo_burst_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        AW,
        W,
        B
    } state_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    // Bytes covered by one burst; the address step between consecutive bursts.
    function automatic int byte_stride(input int burst_len, input int data_width);
        return burst_len * (data_width / 8);
    endfunction

endpackage

// File: rtl/wr_fifo_skid_buf.sv
// Two-entry register FIFO sitting between the FIFO read port and the AXI W channel.
module wr_fifo_skid_buf #(
    parameter int c_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [c_WIDTH-1:0] din,
    input  logic               pop,
    output logic [c_WIDTH-1:0] dout,
    output logic [1:0]         occupancy
);

    logic [c_WIDTH-1:0] mem [2];
    logic               wr_ptr;
    logic               rd_ptr;

    assign dout = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0]    <= '0;
            mem[1]    <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            occupancy <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occupancy <= occupancy + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: rtl/wr_fifo_burst_writer.sv
// Drains the write FIFO into fixed-length AXI write bursts, one frame at a time.
module wr_fifo_burst_writer
    import wr_fifo_burst_pkg::*;
#(
    parameter int c_DATA_WIDTH   = 32,
    parameter int c_ADDR_WIDTH   = 28,
    parameter int c_LEVEL_WIDTH  = 11,
    parameter int c_BURST_LEN    = 16,
    parameter int c_FRAME_BURSTS = 1200
) (
    input  logic                      rd_clk,
    input  logic                      rd_rst,
    input  logic                      frame_start,
    input  logic [c_ADDR_WIDTH-1:0]   frame_base,
    output logic                      fifo_rd_en,
    input  logic [c_DATA_WIDTH-1:0]   fifo_rd_data,
    input  logic                      fifo_rd_empty,
    input  logic [c_LEVEL_WIDTH-1:0]  fifo_rd_water_level,
    output logic [c_ADDR_WIDTH-1:0]   awaddr,
    output logic [7:0]                awlen,
    output logic                      awvalid,
    input  logic                      awready,
    output logic [c_DATA_WIDTH-1:0]   wdata,
    output logic [c_DATA_WIDTH/8-1:0] wstrb,
    output logic                      wlast,
    output logic                      wvalid,
    input  logic                      wready,
    input  logic [1:0]                bresp,
    input  logic                      bvalid,
    output logic                      bready,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      err
);

    localparam int STRIDE = byte_stride(c_BURST_LEN, c_DATA_WIDTH);
    localparam int CNT_W  = $clog2(c_BURST_LEN + 1);
    localparam int FB_W   = $clog2(c_FRAME_BURSTS + 1);

    state_t                  state;
    logic [c_ADDR_WIDTH-1:0] cur_addr;
    logic [FB_W-1:0]         burst_cnt;
    logic [CNT_W-1:0]        req_cnt;
    logic [CNT_W-1:0]        beat_cnt;
    logic                    in_flight;
    logic [1:0]              occ;
    logic                    pop;

    wr_fifo_skid_buf #(
        .c_WIDTH (c_DATA_WIDTH)
    ) u_skid (
        .clk       (rd_clk),
        .rst       (rd_rst),
        .push      (in_flight),
        .din       (fifo_rd_data),
        .pop       (pop),
        .dout      (wdata),
        .occupancy (occ)
    );

    assign busy   = (state != IDLE);
    assign wvalid = (occ != 2'd0);
    assign pop    = wvalid && wready;
    assign wlast  = wvalid && (beat_cnt == CNT_W'(c_BURST_LEN - 1));
    assign wstrb  = {(c_DATA_WIDTH/8){wvalid}};

    // Room check counts the word already requested last cycle, so the skid never overflows.
    assign fifo_rd_en = (state == W) && (req_cnt < CNT_W'(c_BURST_LEN)) && !fifo_rd_empty
                        && ((3'(occ) + 3'(in_flight)) < (3'd2 + 3'(pop)));

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state      <= IDLE;
            cur_addr   <= '0;
            burst_cnt  <= '0;
            req_cnt    <= '0;
            beat_cnt   <= '0;
            in_flight  <= 1'b0;
            awaddr     <= '0;
            awlen      <= 8'd0;
            awvalid    <= 1'b0;
            bready     <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            in_flight  <= fifo_rd_en;
            if (fifo_rd_en) req_cnt  <= req_cnt + 1'b1;
            if (pop)        beat_cnt <= beat_cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (frame_start) begin
                        cur_addr  <= frame_base;
                        burst_cnt <= '0;
                        err       <= 1'b0;
                        state     <= ARMED;
                    end
                end
                ARMED: begin
                    // A restart wins over a pending burst launch.
                    if (frame_start) begin
                        cur_addr  <= frame_base;
                        burst_cnt <= '0;
                    end else if (32'(fifo_rd_water_level) >= c_BURST_LEN) begin
                        awaddr  <= cur_addr;
                        awlen   <= 8'(c_BURST_LEN - 1);
                        awvalid <= 1'b1;
                        state   <= AW;
                    end
                end
                AW: begin
                    if (awready) begin
                        awvalid  <= 1'b0;
                        req_cnt  <= '0;
                        beat_cnt <= '0;
                        state    <= W;
                    end
                end
                W: begin
                    if (pop && wlast) begin
                        bready <= 1'b1;
                        state  <= B;
                    end
                end
                B: begin
                    if (bvalid) begin
                        bready    <= 1'b0;
                        burst_cnt <= burst_cnt + 1'b1;
                        if (bresp != OKAY) err <= 1'b1;
                        if (burst_cnt == FB_W'(c_FRAME_BURSTS - 1)) begin
                            frame_done <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            cur_addr <= cur_addr + c_ADDR_WIDTH'(STRIDE);
                            state    <= ARMED;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wr_fifo_burst_writer.sv
// Directed bench: FIFO model, AXI slave responder, monitors and checks.
module tb_wr_fifo_burst_writer;

    logic        rd_clk = 1'b0;
    logic        rd_rst = 1'b1;
    logic        frame_start = 1'b0;
    logic [27:0] frame_base = '0;
    logic        fifo_rd_en;
    logic [31:0] fifo_rd_data = '0;
    logic        fifo_rd_empty;
    logic [10:0] fifo_rd_water_level;
    logic [27:0] awaddr;
    logic [7:0]  awlen;
    logic        awvalid;
    logic        awready = 1'b1;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready = 1'b1;
    logic [1:0]  bresp = 2'b00;
    logic        bvalid = 1'b0;
    logic        bready;
    logic        busy;
    logic        frame_done;
    logic        err;

    wr_fifo_burst_writer #(
        .c_DATA_WIDTH   (32),
        .c_ADDR_WIDTH   (28),
        .c_LEVEL_WIDTH  (11),
        .c_BURST_LEN    (16),
        .c_FRAME_BURSTS (4)
    ) dut (
        .rd_clk              (rd_clk),
        .rd_rst              (rd_rst),
        .frame_start         (frame_start),
        .frame_base          (frame_base),
        .fifo_rd_en          (fifo_rd_en),
        .fifo_rd_data        (fifo_rd_data),
        .fifo_rd_empty       (fifo_rd_empty),
        .fifo_rd_water_level (fifo_rd_water_level),
        .awaddr              (awaddr),
        .awlen               (awlen),
        .awvalid             (awvalid),
        .awready             (awready),
        .wdata               (wdata),
        .wstrb               (wstrb),
        .wlast               (wlast),
        .wvalid              (wvalid),
        .wready              (wready),
        .bresp               (bresp),
        .bvalid              (bvalid),
        .bready              (bready),
        .busy                (busy),
        .frame_done          (frame_done),
        .err                 (err)
    );

    always #5 rd_clk = ~rd_clk;

    // FIFO model: data appears the cycle after the read enable
    logic [31:0] mem [1024];
    int          wp = 0;
    int          rp = 0;
    logic        lvl_force = 1'b0;
    logic [10:0] lvl_val = '0;

    assign fifo_rd_empty       = (wp == rp);
    assign fifo_rd_water_level = lvl_force ? lvl_val : 11'(wp - rp);

    always @(posedge rd_clk) begin
        if (fifo_rd_en) begin
            fifo_rd_data <= mem[rp % 1024];
            rp           <= rp + 1;
        end
    end

    // AXI slave: optional random wready, one B response per bready, selectable SLVERR
    logic wr_rand = 1'b0;
    int   slv_idx = -1;
    int   b_n = 0;

    always @(posedge rd_clk) begin
        wready <= wr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (bready && !bvalid) begin
            bvalid <= 1'b1;
            bresp  <= (b_n == slv_idx) ? 2'b10 : 2'b00;
        end else begin
            bvalid <= 1'b0;
            bresp  <= 2'b00;
        end
    end

    // Monitors
    logic [27:0] aw_log [64];
    logic [31:0] w_log  [512];
    logic        wl_log [512];
    int          aw_n = 0, w_n = 0, fd_n = 0, ren_n = 0, hold_viol = 0;
    logic        pw_pend = 1'b0;
    logic [31:0] pw_data = '0;

    always @(posedge rd_clk) begin
        if (awvalid && awready) begin
            aw_log[aw_n % 64] <= awaddr;
            aw_n <= aw_n + 1;
        end
        if (wvalid && wready) begin
            w_log[w_n % 512]  <= wdata;
            wl_log[w_n % 512] <= wlast;
            w_n <= w_n + 1;
        end
        if (bvalid && bready) b_n <= b_n + 1;
        if (frame_done) fd_n <= fd_n + 1;
        if (fifo_rd_en) ren_n <= ren_n + 1;
        if (pw_pend && !rd_rst && (!wvalid || wdata != pw_data)) hold_viol <= hold_viol + 1;
        pw_pend <= wvalid && !wready && !rd_rst;
        pw_data <= wdata;
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic fill(input int n, input int start);
        for (int i = 0; i < n; i++) begin
            mem[wp % 1024] = 32'(start + i);
            wp++;
        end
    endtask

    task automatic start_frame(input logic [27:0] base);
        frame_base  = base;
        frame_start = 1'b1;
        @(negedge rd_clk);
        frame_start = 1'b0;
    endtask

    task automatic pulse_rst();
        rd_rst = 1'b1;
        @(negedge rd_clk);
        rd_rst = 1'b0;
        wp = rp;
    endtask

    task automatic wait_b(input int target, input string tag);
        int t = 0;
        while (b_n < target && t < 3000) begin
            @(negedge rd_clk);
            t++;
        end
        chk(tag, 64'(b_n), 64'(target));
    endtask

    task automatic wait_fd(input string tag);
        int t = 0;
        while (frame_done !== 1'b1 && t < 3000) begin
            @(negedge rd_clk);
            t++;
        end
        chk(tag, 64'(frame_done), 64'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_ctl"}, {56'd0, fifo_rd_en, awvalid, wvalid, wlast, bready, busy, frame_done, err}, 64'd0);
        chk({tag, "_addr"}, 64'({awaddr, awlen}), 64'd0);
        chk({tag, "_wdata"}, 64'({wdata, wstrb}), 64'd0);
    endtask

    initial begin
        int wbase, abase, bbase, rbase, wl_cnt, t;

        repeat (3) @(negedge rd_clk);
        check_idle_outputs("reset");
        rd_rst = 1'b0;
        @(negedge rd_clk);

        // Full frame of four bursts with everything ready
        fill(64, 0);
        wbase = w_n; abase = aw_n;
        start_frame(28'h1000);
        wait_fd("f1_done");
        repeat (3) @(negedge rd_clk);
        chk("f1_aw_cnt", 64'(aw_n - abase), 64'd4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("f1_awaddr%0d", k), 64'(aw_log[(abase + k) % 64]), 64'(28'h1000 + 28'(k * 64)));
        chk("f1_w_cnt", 64'(w_n - wbase), 64'd64);
        wl_cnt = 0;
        for (int k = 0; k < 64; k++) begin
            chk($sformatf("f1_beat%0d", k), 64'(w_log[(wbase + k) % 512]), 64'(k));
            if (wl_log[(wbase + k) % 512]) wl_cnt++;
        end
        chk("f1_wlast_cnt", 64'(wl_cnt), 64'd4);
        chk("f1_wlast_pos", {60'd0, wl_log[(wbase + 15) % 512], wl_log[(wbase + 31) % 512],
                             wl_log[(wbase + 47) % 512], wl_log[(wbase + 63) % 512]}, 64'hF);
        chk("f1_fd_pulses", 64'(fd_n), 64'd1);
        chk("f1_awlen", 64'(awlen), 64'd15);
        chk("f1_busy", 64'(busy), 64'd0);

        // Water-level gate, restart while armed, W-entry latency, random wready
        lvl_force = 1'b1; lvl_val = 11'd15;
        wbase = w_n; bbase = b_n; rbase = ren_n;
        start_frame(28'h9000);
        repeat (4) @(negedge rd_clk);
        chk("gate_no_aw", 64'(awvalid), 64'd0);
        chk("gate_busy", 64'(busy), 64'd1);
        start_frame(28'h4000);
        fill(20, 100);
        repeat (2) @(negedge rd_clk);
        chk("gate15_no_aw", 64'(awvalid), 64'd0);
        lvl_val = 11'd16;
        @(negedge rd_clk);
        chk("gate16_aw", 64'(awvalid), 64'd1);
        chk("relatch_awaddr", 64'(awaddr), 64'h4000);
        lvl_val = 11'd15;
        @(negedge rd_clk);
        chk("w_entry_rden", {62'd0, fifo_rd_en, wvalid}, 64'b10);
        @(negedge rd_clk);
        chk("w_entry_p1", 64'(wvalid), 64'd0);
        @(negedge rd_clk);
        chk("w_entry_p2", 64'(wvalid), 64'd1);
        chk("w_first_data", 64'(wdata), 64'd100);
        wr_rand = 1'b1;
        wait_b(bbase + 1, "rand_b_done");
        wr_rand = 1'b0;
        chk("rand_w_cnt", 64'(w_n - wbase), 64'd16);
        for (int k = 0; k < 16; k++)
            chk($sformatf("rand_beat%0d", k), 64'(w_log[(wbase + k) % 512]), 64'(100 + k));
        chk("rand_wlast", 64'(wl_log[(wbase + 15) % 512]), 64'd1);
        chk("rand_rden_cnt", 64'(ren_n - rbase), 64'd16);
        chk("rand_hold", 64'(hold_viol), 64'd0);
        lvl_force = 1'b0;
        pulse_rst();

        // SLVERR on the second burst is sticky until the next frame_start
        fill(64, 300);
        bbase = b_n;
        slv_idx = bbase + 1;
        start_frame(28'h3000);
        wait_b(bbase + 1, "slv_b1");
        chk("slv_err_before", 64'(err), 64'd0);
        wait_b(bbase + 2, "slv_b2");
        chk("slv_err_set", 64'(err), 64'd1);
        wait_fd("slv_done");
        chk("slv_err_at_done", 64'(err), 64'd1);
        @(negedge rd_clk);
        chk("slv_err_idle", 64'(err), 64'd1);
        start_frame(28'h3000);
        chk("slv_err_clear", 64'(err), 64'd0);
        chk("slv_busy", 64'(busy), 64'd1);
        slv_idx = -1;
        pulse_rst();

        // Reset in the middle of a burst
        fill(64, 200);
        wbase = w_n;
        start_frame(28'h5000);
        t = 0;
        while ((w_n - wbase) < 7 && t < 500) begin
            @(negedge rd_clk);
            t++;
        end
        chk("rst_reach_beat7", 64'(w_n - wbase), 64'd7);
        rd_rst = 1'b1;
        @(negedge rd_clk);
        check_idle_outputs("midw_rst");
        rd_rst = 1'b0;
        @(negedge rd_clk);
        wp = rp;
        fill(16, 500);
        start_frame(28'h2000);
        t = 0;
        while (awvalid !== 1'b1 && t < 100) begin
            @(negedge rd_clk);
            t++;
        end
        chk("post_rst_awvalid", 64'(awvalid), 64'd1);
        chk("post_rst_awaddr", 64'(awaddr), 64'h2000);
        pulse_rst();

        // Address wraps modulo 2^28
        fill(32, 700);
        abase = aw_n; bbase = b_n;
        start_frame(28'hFFFFFC0);
        wait_b(bbase + 2, "wrap_b2");
        chk("wrap_aw0", 64'(aw_log[abase % 64]), 64'hFFFFFC0);
        chk("wrap_aw1", 64'(aw_log[(abase + 1) % 64]), 64'h0);
        pulse_rst();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/wr_fifo_burst_writer.md
# wr_fifo_burst_writer

Drains the read side of the write FIFO and moves its contents to the DDR controller as fixed-length AXI-style write bursts. It runs entirely in the FIFO read-clock domain. It waits until the FIFO's read water level covers a whole burst, then issues one address phase and streams the beats. Burst addresses advance linearly from a per-frame base; a completion pulse fires after the last burst of the frame has been acknowledged.

## Interface
Parameters:
- c_DATA_WIDTH, 32, FIFO read data width; equals AXI wdata width.
- c_ADDR_WIDTH, 28, byte address width.
- c_LEVEL_WIDTH, 11, width of the FIFO read water level (FIFO read depth width + 1).
- c_BURST_LEN, 16, beats per burst, range 1..256.
- c_FRAME_BURSTS, 1200, bursts per frame, minimum 1.

Ports:
- rd_clk  in  1  sole clock.
- rd_rst  in  1  reset, synchronous, active-high.
- frame_start  in  1  pulse that arms a new frame.
- frame_base  in  c_ADDR_WIDTH  byte base address, sampled on frame_start.
- fifo_rd_en  out  1  FIFO read enable.
- fifo_rd_data  in  c_DATA_WIDTH  FIFO data, valid one cycle after fifo_rd_en.
- fifo_rd_empty  in  1  FIFO empty flag.
- fifo_rd_water_level  in  c_LEVEL_WIDTH  FIFO read water level.
- awaddr  out  c_ADDR_WIDTH; awlen out 8; awvalid out 1; awready in 1.
- wdata  out  c_DATA_WIDTH; wstrb out c_DATA_WIDTH/8; wlast out 1; wvalid out 1; wready in 1.
- bresp  in  2; bvalid in 1; bready out 1.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse.
- err  out  1  sticky bresp error flag.

## Operation
- FSM states:
  - IDLE: frame_start → ARMED. Latch the base address, clear the burst count and clear err.
  - ARMED: fifo_rd_water_level ≥ c_BURST_LEN → AW. frame_start here re-latches the base and clears the burst count.
  - AW: awvalid=1. On awready → W.
  - W: stream c_BURST_LEN beats. After the handshake of the beat with wlast → B.
  - B: bready=1. On bvalid, OR (bresp≠0) into err and increment the burst count. If the count reaches c_FRAME_BURSTS, pulse frame_done and go to IDLE; otherwise advance the address and go to ARMED.
- frame_start in AW, W or B is ignored.
- awaddr = base + burst_count × c_BURST_LEN × c_DATA_WIDTH/8, modulo 2^c_ADDR_WIDTH (wraps silently).
- awlen = c_BURST_LEN−1. wstrb is all ones. wlast is asserted on beat index c_BURST_LEN−1 only.
- FIFO prefetch through a 2-entry skid buffer:
  - fifo_rd_en = in W, and requested beats < c_BURST_LEN, and !fifo_rd_empty, and (occupancy + in-flight − pop_this_cycle) < 2.
  - Data is never read ahead of the current burst.
- The ARMED water-level gate guarantees the FIFO does not run dry mid-burst. If it does, wvalid deasserts and the burst resumes when data returns; no beat is dropped or duplicated.
- rd_rst in any state:
  - All outputs return to 0 next cycle and the FSM goes to IDLE.
  - The skid buffer and counters clear, and err clears.
  - The in-flight AXI transaction is abandoned (system-level reset assumed).

## Timing
- Reset values: fifo_rd_en, awvalid, wvalid, wlast, bready, busy, frame_done and err are 0; awaddr, awlen and wdata are 0.
- Water level ≥ c_BURST_LEN seen in ARMED at cycle N → awvalid at N+1.
- Entering W at cycle M → first fifo_rd_en at M, first wvalid at M+2. Sustained throughput is 1 beat/cycle with wready held high.
- wready low: the skid buffer holds wdata stable, and fifo_rd_en stalls within one cycle.
- AXI valid/data hold: awvalid and wvalid, with their payloads, stay stable until the matching ready.
- frame_done is asserted in the cycle after the final bvalid && bready.

## Structure
- Package wr_fifo_burst_pkg holds:
  - the FSM state enum (IDLE, ARMED, AW, W, B);
  - the AXI response constants OKAY=2'b00 and SLVERR=2'b10;
  - a function computing the byte stride from c_BURST_LEN and c_DATA_WIDTH.
- Sub-module wr_fifo_skid_buf: 2-entry register FIFO with push/pop/occupancy, parameterised by width.

## Test plan
- c_BURST_LEN=16, c_FRAME_BURSTS=4, frame_base=0x1000, FIFO prefilled with 64 incrementing words, wready/awready constantly high → 4 bursts at 0x1000/0x1040/0x1080/0x10C0, data 0..63 in order, wlast on beats 15/31/47/63, one frame_done pulse.
- Water level held at 15 → no awvalid; raise it to 16 → awvalid exactly one cycle later.
- Random wready (50%) during a burst → all 16 beats delivered exactly once and in order, and fifo_rd_en count equals 16.
- bresp=SLVERR on burst 2 → err rises and stays high through frame_done; the next frame_start clears it.
- rd_rst asserted mid-W at beat 7 → all outputs 0 next cycle and busy=0; after release plus frame_start with base 0x2000, the first awaddr is 0x2000.
- frame_base near 2^28 boundary (0xFFFFFC0, c_BURST_LEN=16) → second awaddr wraps to 0x0000000.
